// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver:
//   - uart_state_e : receiver FSM state encoding
//   - uart_pulse() : clocks per bit for a given clock and baud rate
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;

    // Clocks per bit, integer-truncated (868 for 100 MHz / 115200).
    function automatic int unsigned uart_pulse(input int unsigned clk_freq,
                                               input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_if.sv
// ---------------------------------------------------------------------------
// uart_if
// Receive bundle between the serial line, the UART receiver and its consumer.
//   sig   : serial line, idles high
//   data  : received word
//   valid : data holds an unconsumed word
//   ready : consumer accepts the word
// Modport rx is the receiver's view (sig/ready in, data/valid out).
// ---------------------------------------------------------------------------
interface uart_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  sig;
    logic [DATA_WIDTH-1:0] data;
    logic                  valid;
    logic                  ready;

    modport rx (
        input  sig,
        input  ready,
        output data,
        output valid
    );
endinterface

// File: rtl/uart_sync2.sv
// ---------------------------------------------------------------------------
// uart_sync2
// Two-flop synchronizer for the asynchronous serial line.
// Ports:
//   clk   : system clock
//   rstn  : asynchronous active-low reset (flops reset to 1 = line idle)
//   d_i   : asynchronous input
//   q_o   : synchronized output
// ---------------------------------------------------------------------------
module uart_sync2 (
    input  logic clk,
    input  logic rstn,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] ff_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ff_q <= 2'b11;
        end else begin
            ff_q <= {ff_q[0], d_i};
        end
    end

    assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
// UART receiver: start bit 0, DATA_WIDTH data bits LSB first, one stop bit,
// no parity. Bit period PULSE = CLK_FREQ / BAUD_RATE clocks.
//
// Ports:
//   clk         : system clock, rising edge
//   rstn        : asynchronous active-low reset
//   rxif        : uart_if.rx bundle (sig, ready in; data, valid out)
//   dbg_state_o : current FSM state, for observation only
//
// Handshake: valid rises the clock after a word completes and then holds,
// with data stable, until a clock where valid && ready; valid drops on that
// clock. ready while valid is low is ignored. A word completing while valid
// is high overwrites data and keeps valid high, and a completion on the same
// clock as a handshake also wins (new word loaded, valid stays high).
//
// Configuration macro:
//   UART_RX_FRAME_CHECK_EN : when defined, a frame whose stop bit samples 0
//                            is dropped; otherwise every frame is delivered.
// ---------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned CLK_FREQ   = 100_000_000
) (
    input  logic        clk,
    input  logic        rstn,
    uart_if.rx          rxif,
    output uart_state_e dbg_state_o
);

    localparam int unsigned PULSE = uart_pulse(CLK_FREQ, BAUD_RATE);
    localparam int unsigned HALF  = PULSE / 2;
    localparam int unsigned CNT_W = (PULSE > 1) ? $clog2(PULSE) : 1;
    localparam int unsigned IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE - 1);
    localparam logic [CNT_W-1:0] HALF_LAST  = CNT_W'((HALF > 0) ? HALF - 1 : 0);
    localparam logic [IDX_W-1:0] BIT_LAST   = IDX_W'(DATA_WIDTH - 1);

    logic                  sig_sync;
    logic                  line_prev_q;
    uart_state_e           state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [IDX_W-1:0]      bit_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;

    uart_sync2 u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d_i  (rxif.sig),
        .q_o  (sig_sync)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            line_prev_q <= 1'b1;
        end else begin
            line_prev_q <= sig_sync;

            // Consumption first; a word completing in STOP on this same clock
            // assigns valid_q again below and therefore takes priority.
            if (valid_q && rxif.ready) begin
                valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    // Requiring a 1 before the 0 also makes the receiver wait
                    // for the line to recover after a frame ending low.
                    if (line_prev_q && !sig_sync) begin
                        state_q <= START;
                        cnt_q   <= '0;
                        bit_q   <= '0;
                    end
                end

                START: begin
                    if (cnt_q == HALF_LAST) begin
                        cnt_q   <= '0;
                        // Line back high at mid start bit: a glitch, drop it.
                        state_q <= sig_sync ? IDLE : DATA;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (cnt_q == PULSE_LAST) begin
                        cnt_q          <= '0;
                        shift_q[bit_q] <= sig_sync;
                        if (bit_q == BIT_LAST) begin
                            state_q <= STOP;
                        end else begin
                            bit_q <= bit_q + IDX_W'(1);
                        end
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (cnt_q == PULSE_LAST) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
`ifdef UART_RX_FRAME_CHECK_EN
                        if (sig_sync) begin
                            data_q  <= shift_q;
                            valid_q <= 1'b1;
                        end
`else
                        data_q  <= shift_q;
                        valid_q <= 1'b1;
`endif
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign rxif.data   = data_q;
    assign rxif.valid  = valid_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
// Bench for uart_rx at 12 clocks per bit (12 MHz clock, 1 Mbit/s line).
// Expected words come from a frame-level model: the line bits of each frame
// are built arithmetically from the word, and the model decides delivery
// from the stop bit and UART_RX_FRAME_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned DW     = 8;
    localparam int unsigned CLK_HZ = 12_000_000;
    localparam int unsigned BAUD   = 1_000_000;
    localparam int unsigned PULSE  = CLK_HZ / BAUD;
    localparam int unsigned HALF   = PULSE / 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    uart_if #(.DATA_WIDTH(DW)) rxif_i ();
    uart_state_e dbg_state;

    uart_rx #(
        .DATA_WIDTH (DW),
        .BAUD_RATE  (BAUD),
        .CLK_FREQ   (CLK_HZ)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .rxif        (rxif_i),
        .dbg_state_o (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int unsigned   n_checks = 0;
    int unsigned   n_fail   = 0;
    logic [DW-1:0] exp_q[$];

    // Data-change monitor: counts word loads and records valid at each load.
    logic [DW-1:0] prev_data = '0;
    int unsigned   chg_cnt   = 0;
    logic          chg_valid = 1'b0;

    always @(negedge clk) begin
        if (rxif_i.data !== prev_data) begin
            chg_cnt   <= chg_cnt + 1;
            chg_valid <= rxif_i.valid;
        end
        prev_data <= rxif_i.data;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_frame(input logic [DW-1:0] w, input logic stop_b);
        logic        frame[$];
        int unsigned word;
        frame.push_back(1'b0);
        for (int i = 0; i < DW; i++) begin
            frame.push_back(((int'(w) / (1 << i)) % 2) == 1);
        end
        frame.push_back(stop_b);
        word = 0;
        for (int i = 0; i < DW; i++) begin
            if (frame[i + 1]) word += (1 << i);
        end
`ifdef UART_RX_FRAME_CHECK_EN
        if (frame[DW + 1]) exp_q.push_back(DW'(word));
`else
        exp_q.push_back(DW'(word));
`endif
        foreach (frame[k]) begin
            rxif_i.sig = frame[k];
            repeat (PULSE) @(negedge clk);
        end
    endtask

    // Word must be visible within HALF+3 clocks of the nominal stop-bit end.
    task automatic wait_word(input string tag);
        int unsigned   waited;
        logic [DW-1:0] exp_w;
        waited = 0;
        while (!rxif_i.valid && waited < HALF + 3) begin
            @(negedge clk);
            waited++;
        end
        check_eq({tag, "_valid"}, 32'(rxif_i.valid), 32'd1);
        if (exp_q.size() > 0) exp_w = exp_q.pop_front();
        else exp_w = 'x;
        check_eq({tag, "_data"}, 32'(rxif_i.data), 32'(exp_w));
    endtask

    task automatic pulse_ready(input string tag);
        rxif_i.ready = 1'b1;
        @(negedge clk);
        rxif_i.ready = 1'b0;
        check_eq(tag, 32'(rxif_i.valid), 32'd0);
    endtask

    task automatic idle_gap();
        rxif_i.sig = 1'b1;
        repeat ($urandom_range(PULSE, 2)) @(negedge clk);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #(95_000 * 10);
        $display("FAIL watchdog run did not complete checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int unsigned   seen;
        int unsigned   c0;
        logic [DW-1:0] w1;
        logic [DW-1:0] w2;

        rxif_i.sig   = 1'b1;
        rxif_i.ready = 1'b0;
        rstn         = 1'b0;
        repeat (4) @(negedge clk);
        check_eq("rst_valid", 32'(rxif_i.valid), 32'd0);
        check_eq("rst_data", 32'(rxif_i.data), 32'd0);
        check_eq("rst_state", 32'(dbg_state), 32'(IDLE));
        rstn = 1'b1;
        repeat (4) @(negedge clk);

        // Glitch shorter than half a bit: no word, FSM back in IDLE.
        rxif_i.sig = 1'b0;
        repeat (HALF / 2) @(negedge clk);
        rxif_i.sig = 1'b1;
        seen = 0;
        repeat (3 * PULSE) begin
            @(negedge clk);
            if (rxif_i.valid) seen++;
        end
        check_eq("glitch_no_valid", seen, 0);
        check_eq("glitch_state", 32'(dbg_state), 32'(IDLE));
        send_frame(8'h3C, 1'b1);
        wait_word("glitch_next");
        pulse_ready("glitch_clr");
        idle_gap();

        // Hold: word stays put until consumed.
        send_frame(8'hA5, 1'b1);
        wait_word("hold");
        seen = 0;
        repeat (5000) begin
            @(negedge clk);
            if (!rxif_i.valid || rxif_i.data !== 8'hA5) seen++;
        end
        check_eq("hold_stable", seen, 0);
        pulse_ready("hold_clr");
        idle_gap();

        // Overrun: the newest word replaces the unconsumed one.
        send_frame(8'h11, 1'b1);
        idle_gap();
        send_frame(8'h22, 1'b1);
        while (exp_q.size() > 1) void'(exp_q.pop_front());
        wait_word("overrun");
        pulse_ready("overrun_clr");
        idle_gap();

        // Stop bit sampled low.
        send_frame(8'h55, 1'b0);
        rxif_i.sig = 1'b1;
`ifdef UART_RX_FRAME_CHECK_EN
        seen = 0;
        repeat (2 * PULSE) begin
            @(negedge clk);
            if (rxif_i.valid) seen++;
        end
        check_eq("ferr_no_valid", seen, 0);
`else
        wait_word("ferr_word");
        pulse_ready("ferr_clr");
`endif
        idle_gap();
        send_frame(8'($urandom_range(0, 255)), 1'b1);
        wait_word("ferr_next");

        // Reset after 4 data bits of 0xF0, with the previous word still pending.
        rxif_i.sig = 1'b0;
        repeat (PULSE) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rxif_i.sig = ((32'hF0 / (1 << i)) % 2) == 1;
            repeat (PULSE) @(negedge clk);
        end
        rstn = 1'b0;
        #1;
        check_eq("midrst_valid", 32'(rxif_i.valid), 32'd0);
        check_eq("midrst_data", 32'(rxif_i.data), 32'd0);
        check_eq("midrst_state", 32'(dbg_state), 32'(IDLE));
        @(negedge clk);
        rxif_i.sig = 1'b1;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        repeat (3) @(negedge clk);
        send_frame(8'h0F, 1'b1);
        wait_word("midrst_next");
        pulse_ready("midrst_clr");
        idle_gap();

        // A one-clock ready pulse swept across the end of a second frame while
        // the first word is still pending; whenever a word loads, valid is high.
        for (int o = 0; o < int'(PULSE + HALF + 4); o++) begin
            w1 = 8'($urandom_range(0, 255));
            w2 = ~w1;
            send_frame(w1, 1'b1);
            wait_word("simul_first");
            @(negedge clk);
            c0 = chg_cnt;
            fork
                send_frame(w2, 1'b1);
                begin
                    repeat ((DW + 1) * PULSE + o) @(negedge clk);
                    rxif_i.ready = 1'b1;
                    @(negedge clk);
                    rxif_i.ready = 1'b0;
                end
            join
            repeat (HALF + 4) @(negedge clk);
            check_eq("simul_loads", chg_cnt - c0, 1);
            check_eq("simul_valid_on_load", 32'(chg_valid), 32'd1);
            if (exp_q.size() > 0) w1 = exp_q.pop_front();
            else w1 = 'x;
            check_eq("simul_data", 32'(rxif_i.data), 32'(w1));
            if (rxif_i.valid) pulse_ready("simul_clr");
            idle_gap();
        end

        // Sweep every byte value with a randomly delayed consumer.
        for (int b = 0; b < 256; b++) begin
            send_frame(8'(b), 1'b1);
            wait_word("sweep");
            repeat ($urandom_range(PULSE, HALF)) @(negedge clk);
            pulse_ready("sweep_clr");
            repeat ($urandom_range(PULSE, 0)) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 Parameter BAUD_RATE, default 115200, line bit rate in bit/s.
REQ-003 Parameter CLK_FREQ, default 100_000_000, clk frequency in Hz.
REQ-004 Clocking and reset: one clock; reset is asynchronous and active-low.
REQ-005 clk  input  1  system clock; all logic on its rising edge.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 rxif  interface port  uart_if #(DATA_WIDTH)  receive bundle; signals listed in REQ-008 to REQ-011.
REQ-008 rxif.sig  input  1  serial line; idles high.
REQ-009 rxif.data  output  DATA_WIDTH  received word.
REQ-010 rxif.valid  output  1  rxif.data holds an unconsumed word.
REQ-011 rxif.ready  input  1  consumer accepts the word.

Function
REQ-012 Frame format: start bit 0, DATA_WIDTH data bits LSB first, one stop bit 1, no parity.
REQ-013 Bit period: PULSE = CLK_FREQ/BAUD_RATE clocks, integer-truncated (868 at the defaults); half period: HALF = PULSE/2.
REQ-014 rxif.sig passes through a 2-flop synchronizer before use; all timing counts from the synchronized signal.
REQ-015 FSM states: IDLE, START, DATA, STOP.
REQ-016 IDLE: a synchronized 1->0 transition moves to START and clears the bit counter.
REQ-017 START: after HALF clocks, sample the line; if 0, go to DATA; if 1 (glitch), return to IDLE with no output.
REQ-018 DATA: sample every PULSE clocks; sample i goes to shift-register bit i; after DATA_WIDTH samples, go to STOP.
REQ-019 STOP: after PULSE clocks, sample the stop bit; store the word in rxif.data and set rxif.valid on the next clock; return to IDLE.
REQ-020 rxif.valid stays high and rxif.data stays stable until a clock where rxif.valid && rxif.ready; rxif.valid clears on that clock.
REQ-021 rxif.ready while rxif.valid is low has no effect.
REQ-022 Reception continues while rxif.valid is high.
REQ-023 Overrun: if a new word completes while rxif.valid is high, it overwrites rxif.data and rxif.valid stays high.
REQ-024 Simultaneous completion and handshake: the new word loads and rxif.valid stays high.
REQ-025 A word is available no later than HALF+3 clocks after the nominal end of the stop bit.

Reset
REQ-026 rstn low forces: state IDLE, counters 0, shift register 0, rxif.data 0, rxif.valid 0, synchronizer flops 1.
REQ-027 Reset mid-frame discards the partial frame; after release, the block waits for a fresh falling edge.

Configuration
REQ-028 With UART_RX_FRAME_CHECK_EN defined: a frame whose sampled stop bit is 0 is discarded, rxif.valid is not set, and the FSM waits in IDLE for the line to return to 1 before accepting a new start bit.
REQ-029 With UART_RX_FRAME_CHECK_EN undefined: the stop-bit value is ignored and every frame is delivered.

Structure
REQ-030 Package uart_pkg holds the FSM state enum typedef and a function returning PULSE from CLK_FREQ and BAUD_RATE.
REQ-031 Interface uart_if #(DATA_WIDTH) declares sig, data, valid and ready, with modport rx (sig and ready in; data and valid out) used by uart_rx.
REQ-032 A single sub-module, uart_sync2 (2-flop synchronizer, reset value 1), is instantiated for rxif.sig; all other logic sits in uart_rx.

Verification
REQ-033 Exhaustive sweep: send bytes 0x00 to 0xFF at 868 clocks per bit, pulsing ready for 1 clock after a random 434 to 868 clock delay -> every rxif.data equals the byte sent.
REQ-034 Hold: send 0xA5 and keep ready low for 5000 clocks -> valid stays 1 and data stays 0xA5 throughout; a one-clock ready pulse clears valid the next clock.
REQ-035 Glitch: drive sig low for 200 clocks, then high -> no valid and FSM back in IDLE; a following 0x3C frame is received correctly.
REQ-036 Overrun: send 0x11 then 0x22 with ready low -> data = 0x22, valid = 1.
REQ-037 Frame error: 0x55 with stop bit 0 -> no valid with UART_RX_FRAME_CHECK_EN defined; valid with data 0x55 without it.
REQ-038 Reset mid-frame: assert rstn after 4 data bits of 0xF0 -> valid 0 and data 0 immediately; the next full 0x0F frame is received correctly.
